// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the two-lane subtractor hierarchy:
// default lane widths and the two's-complement overflow predicate.
package arith_pkg;

  localparam int N1_DEF = 16;
  localparam int N2_DEF = 8;

  // Subtraction a-b overflows when the operands differ in sign and the
  // result's sign differs from the minuend's sign.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                   input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/subtractor_hier_pipe_if.sv
// Valid/ready operand and result bus for the two-lane subtractor.
// The master modport is the producer/consumer side, slave is the block.
interface subtractor_hier_pipe_if #(
  parameter int N1 = 16,
  parameter int N2 = 8
);

  logic          in_valid;
  logic          in_ready;
  logic [N1-1:0] A;
  logic [N1-1:0] B;
  logic [N2-1:0] C;
  logic [N2-1:0] D;
  logic          out_valid;
  logic          out_ready;
  logic [N1:0]   S;
  logic [N2:0]   T;
  logic          overflow;

  modport master (
    output in_valid, A, B, C, D, out_ready,
    input  in_ready, out_valid, S, T, overflow
  );

  modport slave (
    input  in_valid, A, B, C, D, out_ready,
    output in_ready, out_valid, S, T, overflow
  );

endinterface

// File: rtl/subn_pipe.sv
// Two-stage lane subtractor: the low half is subtracted in stage 1, the
// high half (with the registered low borrow) in stage 2. Stage loading is
// controlled entirely by the enclosing pipeline through ld1/ld2.
module subn_pipe
  import arith_pkg::*;
#(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld1,
  input  logic         ld2,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n:0]   diff,
  output logic         ovf_nxt
);

  localparam int L = n / 2;
  localparam int H = n - L;

  logic [L:0]   lo_full;
  logic [L-1:0] lo_q;
  logic         bor_q;
  // The upper halves carry the operand MSBs, so no separate MSB flops.
  logic [H-1:0] ahi_q;
  logic [H-1:0] bhi_q;
  logic [H:0]   hi_full;

  assign lo_full = {1'b0, a[L-1:0]} - {1'b0, b[L-1:0]};
  assign hi_full = {1'b0, ahi_q} - {1'b0, bhi_q} - {{H{1'b0}}, bor_q};
  assign ovf_nxt = sub_ovf(ahi_q[H-1], bhi_q[H-1], hi_full[H-1]);

  // Stage 1: capture low difference, low borrow and the upper halves.
  // NOTE: state is written with non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: data registers are reset too, so outputs read zero after reset
    // rather than stale or X values.
    if (!rst_n) begin
      lo_q  <= '0;
      bor_q <= 1'b0;
      ahi_q <= '0;
      bhi_q <= '0;
    end else if (ld1) begin
      lo_q  <= lo_full[L-1:0];
      bor_q <= lo_full[L];
      ahi_q <= a[n-1:L];
      bhi_q <= b[n-1:L];
    end
  end

  // Stage 2: complete the high half; its borrow-out is the lane borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff <= '0;
    end else if (ld2) begin
      diff <= {hi_full[H], hi_full[H-1:0], lo_q};
    end
  end

endmodule

// File: rtl/subtractor_hier_pipe.sv
// Two-lane pipelined subtractor: lane 1 computes A-B, lane 2 computes C-D,
// each as a two-stage split subtraction. This level owns the valid/ready
// control and the registered overflow OR of both lanes.
module subtractor_hier_pipe
  import arith_pkg::*;
#(
  parameter int N1 = N1_DEF,
  parameter int N2 = N2_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  subtractor_hier_pipe_if.slave bus
);

  logic s1_valid;
  logic s2_valid;
  logic adv1;
  logic adv2;
  logic ld1;
  logic ld2;
  logic ovf1_nxt;
  logic ovf2_nxt;
  logic ovf_q;
  logic [N1:0] s_q;
  logic [N2:0] t_q;

  // A stage may advance when it is empty or its successor advances, so
  // bubbles collapse under backpressure.
  assign adv2 = !s2_valid || bus.out_ready;
  assign adv1 = !s1_valid || adv2;
  assign ld1  = adv1 && bus.in_valid;
  assign ld2  = adv2 && s1_valid;

  assign bus.in_ready  = adv1;
  assign bus.out_valid = s2_valid;
  assign bus.S         = s_q;
  assign bus.T         = t_q;
  assign bus.overflow  = ovf_q;

  subn_pipe #(.n(N1)) u_lane1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld1     (ld1),
    .ld2     (ld2),
    .a       (bus.A),
    .b       (bus.B),
    .diff    (s_q),
    .ovf_nxt (ovf1_nxt)
  );

  subn_pipe #(.n(N2)) u_lane2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld1     (ld1),
    .ld2     (ld2),
    .a       (bus.C),
    .b       (bus.D),
    .diff    (t_q),
    .ovf_nxt (ovf2_nxt)
  );

  // Stage valid bits track occupancy; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (adv1) s1_valid <= bus.in_valid;
      if (adv2) s2_valid <= s1_valid;
    end
  end

  // Combined overflow is registered alongside the stage-2 differences.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (ld2) begin
      ovf_q <= ovf1_nxt | ovf2_nxt;
    end
  end

endmodule

// File: tb/tb_subtractor_hier_pipe.sv
// Self-checking bench for subtractor_hier_pipe: directed vectors, stall,
// random streaming and mid-stream reset, scored against an arithmetic model.
module tb_subtractor_hier_pipe;

  localparam int N1 = 16;
  localparam int N2 = 8;

  typedef struct packed {
    logic [N1:0] s;
    logic [N2:0] t;
    logic        ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  subtractor_hier_pipe_if #(.N1(N1), .N2(N2)) bus ();

  subtractor_hier_pipe #(.N1(N1), .N2(N2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int n_out    = 0;
  int acc_cyc  = 0;
  int out_cyc  = 0;
  logic smp_ov, smp_ir, stall_prev;
  logic [N1:0] held_s;
  logic [N2:0] held_t;
  logic        held_o;
  logic [N1:0] last_s;
  logic [N2:0] last_t;
  logic        last_o;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the whole operands.
  function automatic exp_t model(input logic [N1-1:0] a, input logic [N1-1:0] b,
                                 input logic [N2-1:0] c, input logic [N2-1:0] d);
    exp_t r;
    int da, dc;
    logic [N1-1:0] sl;
    logic [N2-1:0] tl;
    sl = a - b;
    tl = c - d;
    da = int'($signed(a)) - int'($signed(b));
    dc = int'($signed(c)) - int'($signed(d));
    r.s  = {(a < b), sl};
    r.t  = {(c < d), tl};
    r.ov = (da > 32767) || (da < -32768) || (dc > 127) || (dc < -128);
    return r;
  endfunction

  task automatic drive(input logic v, input logic [N1-1:0] a, input logic [N1-1:0] b,
                       input logic [N2-1:0] c, input logic [N2-1:0] d);
    bus.in_valid = v;
    bus.A = a;
    bus.B = b;
    bus.C = c;
    bus.D = d;
  endtask

  // One clock: observe handshakes at the falling edge, score, then return
  // just after the next rising edge so the caller can drive new inputs.
  task automatic cycle();
    exp_t e;
    logic fi, fo;
    @(negedge clk);
    cyc++;
    fi = bus.in_valid && bus.in_ready;
    fo = bus.out_valid && bus.out_ready;
    smp_ov = bus.out_valid;
    smp_ir = bus.in_ready;
    if (stall_prev) begin
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_s", 32'(bus.S), 32'(held_s));
      check("stall_t", 32'(bus.T), 32'(held_t));
      check("stall_ovf", 32'(bus.overflow), 32'(held_o));
    end
    if (fo) begin
      if (q.size() == 0) begin
        check("spurious_out", 32'(bus.out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        check("sb_s", 32'(bus.S), 32'(e.s));
        check("sb_t", 32'(bus.T), 32'(e.t));
        check("sb_ovf", 32'(bus.overflow), 32'(e.ov));
      end
      last_s = bus.S;
      last_t = bus.T;
      last_o = bus.overflow;
      n_out++;
      out_cyc = cyc;
    end
    if (fi) begin
      q.push_back(model(bus.A, bus.B, bus.C, bus.D));
      n_acc++;
      acc_cyc = cyc;
    end
    stall_prev = bus.out_valid && !bus.out_ready;
    held_s = bus.S;
    held_t = bus.T;
    held_o = bus.overflow;
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input string tag, input logic [N1-1:0] a,
                          input logic [N1-1:0] b, input logic [N2-1:0] c,
                          input logic [N2-1:0] d, input logic [N1:0] es,
                          input logic [N2:0] et, input logic eo);
    int n0;
    int k;
    bus.out_ready = 1'b1;
    drive(1'b1, a, b, c, d);
    n0 = n_acc;
    k = 0;
    while (n_acc == n0 && k < 10) begin cycle(); k++; end
    check({tag, "_accepted"}, 32'(n_acc - n0), 32'd1);
    drive(1'b0, '0, '0, '0, '0);
    n0 = n_out;
    k = 0;
    while (n_out == n0 && k < 10) begin cycle(); k++; end
    check({tag, "_emitted"}, 32'(n_out - n0), 32'd1);
    check({tag, "_latency"}, 32'(out_cyc - acc_cyc), 32'd2);
    check({tag, "_s"}, 32'(last_s), 32'(es));
    check({tag, "_t"}, 32'(last_t), 32'(et));
    check({tag, "_ovf"}, 32'(last_o), 32'(eo));
    cycle();
    check({tag, "_one_cycle"}, 32'(smp_ov), 32'd0);
  endtask

  initial begin
    logic [N1-1:0] sa [4];
    logic [N1-1:0] sb [4];
    logic [N2-1:0] sc [4];
    logic [N2-1:0] sd [4];
    int idx, k, n0, first;

    stall_prev = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_s", 32'(bus.S), 32'd0);
    check("rst_t", 32'(bus.T), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    // Directed vectors from arithmetic corner cases.
    send_one("basic", 16'h0005, 16'h0003, 8'h10, 8'h01, 17'h0_0002, 9'h0_0F, 1'b0);
    send_one("split_borrow", 16'h0100, 16'h0001, 8'h00, 8'h00, 17'h0_00FF, 9'h000, 1'b0);
    send_one("wrap", 16'h0000, 16'h0001, 8'h00, 8'h00, 17'h1_FFFF, 9'h000, 1'b0);
    send_one("ovf_lane2", 16'h0000, 16'h0000, 8'h80, 8'h01, 17'h0_0000, 9'h0_7F, 1'b1);
    send_one("ovf_lane1", 16'h7FFF, 16'hFFFF, 8'h00, 8'h00, 17'h1_8000, 9'h000, 1'b1);

    // Backpressure: four sets offered while the consumer stalls.
    for (int i = 0; i < 4; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = 16'($urandom);
      sc[i] = 8'($urandom);
      sd[i] = 8'($urandom);
    end
    bus.out_ready = 1'b0;
    idx = 0;
    n0 = n_out;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, sa[idx], sb[idx], sc[idx], sd[idx]);
      k = n_acc;
      cycle();
      if (n_acc != k) idx++;
    end
    check("bp_accepted", 32'(idx), 32'd2);
    check("bp_in_ready", 32'(smp_ir), 32'd0);
    check("bp_no_out", 32'(n_out - n0), 32'd0);
    bus.out_ready = 1'b1;
    k = 0;
    while ((idx < 4 || q.size() != 0) && k < 20) begin
      if (idx < 4) drive(1'b1, sa[idx], sb[idx], sc[idx], sd[idx]);
      else drive(1'b0, '0, '0, '0, '0);
      n0 = n_acc;
      cycle();
      if (n_acc != n0) idx++;
      k++;
    end
    drive(1'b0, '0, '0, '0, '0);
    check("bp_all_sent", 32'(idx), 32'd4);
    check("bp_drained", 32'(q.size()), 32'd0);

    // Full throughput: random back-to-back stream.
    n0 = n_out;
    first = -1;
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
      k = n_out;
      cycle();
      check("tp_in_ready", 32'(smp_ir), 32'd1);
      if (n_out != k && first < 0) first = out_cyc;
    end
    drive(1'b0, '0, '0, '0, '0);
    k = 0;
    while (q.size() != 0 && k < 10) begin
      cycle();
      if (first < 0 && n_out != n0) first = out_cyc;
      k++;
    end
    check("tp_count", 32'(n_out - n0), 32'd32);
    check("tp_back_to_back", 32'(out_cyc - first), 32'd31);

    // Reset with two results in flight.
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h1234, 16'h0034, 8'h55, 8'h05);
    cycle();
    drive(1'b1, 16'h4321, 16'h0021, 8'h66, 8'h06);
    cycle();
    drive(1'b0, '0, '0, '0, '0);
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_s", 32'(bus.S), 32'd0);
    check("mid_rst_t", 32'(bus.T), 32'd0);
    q.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_one("post_rst", 16'h0010, 16'h0020, 8'h7F, 8'hFF, 17'h1_FFF0, 9'h1_80, 1'b1);
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
